axis_packet_padder: RTL and testbench
=====================================

Name: axis_packet_padder

Overview:
- Sits directly upstream of the narrow-to-wide AXIS packer.
- Pads each packet with fill beats so that:
  - the total beat count is at least MIN_BEATS, and
  - the total beat count is an exact multiple of ALIGN_BEATS.
- With ALIGN_BEATS equal to the packer ratio, the packer never sees an early tlast and never zero-fills a partial wide word.
- Fill bytes are programmable. Payload passes through unmodified.

Parameters:
- AXIS_BYTES, 1, tdata width in bytes on both sides.
- MIN_BEATS, 60, minimum output beats per packet; 0 or 1 disables the minimum.
- ALIGN_BEATS, 4, output packet length must be a multiple of this; 1 disables alignment.
- PAD_BYTE, 8'h00, value replicated into every byte lane of fill beats.

Ports:
- clk  in  1  clock
- sresetn  in  1  reset; asynchronous assert, active-low
- axis_i_tready  out  1  input ready
- axis_i_tvalid  in  1  input valid
- axis_i_tlast  in  1  input end of packet
- axis_i_tdata  in  AXIS_BYTES*8  input data
- axis_o_tready  in  1  output ready
- axis_o_tvalid  out  1  output valid
- axis_o_tlast  out  1  output end of packet
- axis_o_tdata  out  AXIS_BYTES*8  output data

Behaviour:
- Clock and reset: one clock, clk. Reset sresetn is asynchronous and active-low.
- Reset values:
  - state=PASS, beat_ctr=0, align_ctr=0.
  - axis_o_tvalid follows axis_i_tvalid combinationally in PASS, so it is 0 whenever the input is idle.
  - axis_i_tready=axis_o_tready in PASS.
- beat_ctr: counts accepted output beats in the current packet, width $clog2(MIN_BEATS+1), saturating at MIN_BEATS.
- align_ctr: counts modulo ALIGN_BEATS and wraps to 0.
- need_pad: true if beat_ctr_next < MIN_BEATS or align_ctr_next != 0, evaluated on the beat being transferred (counters after increment).
- State PASS (zero latency, combinational path):
  - axis_o_tdata=axis_i_tdata, axis_o_tvalid=axis_i_tvalid, axis_i_tready=axis_o_tready.
  - axis_o_tlast = axis_i_tlast && !need_pad.
  - On each transfer (o_tvalid && o_tready), both counters advance.
  - If input tlast is transferred and need_pad is true, go to PAD.
  - If input tlast is transferred and need_pad is false, clear both counters and stay in PASS.
- State PAD:
  - axis_i_tready=0, axis_o_tvalid=1, axis_o_tdata={AXIS_BYTES{PAD_BYTE}}.
  - axis_o_tlast = !need_pad.
  - Counters advance on each transfer.
  - When a tlast beat transfers, clear counters and return to PASS.
- Backpressure: o_tvalid, once asserted in PAD, is held with stable data until tready. No beat is dropped or duplicated.
- Boundary cases:
  - A single-beat packet with MIN_BEATS=0 and ALIGN_BEATS=1 passes with tlast unchanged.
  - A packet longer than MIN_BEATS is padded only for alignment.
  - The beat_ctr saturation point is reached exactly on beat MIN_BEATS.
  - align_ctr wraps on every ALIGN_BEATS boundary independently of beat_ctr.
- Reset mid-packet or mid-PAD: return immediately to PASS with counters cleared. The partial output packet is abandoned without a tlast; downstream is reset by the same signal.
- Elaboration checks: ALIGN_BEATS >= 1; AXIS_BYTES >= 1.

Optional Feature:
- Macro: AXIS_PACKET_PADDER_STATS_EN.
- With it defined:
  - Extra output port pad_pkt_count, out, 32 bits: counts packets that entered PAD, incremented on the PASS-to-PAD transition.
  - Extra output port pad_beat_count, out, 32 bits: counts transferred fill beats.
  - Both reset to 0 and wrap at 2^32.
- Without it: the ports and counters do not exist, and the datapath is identical.

Decomposition:
- Package axis_padder_pkg holds:
  - state typedef enum logic {PASS, PAD};
  - a function computing the beat_ctr width from MIN_BEATS.
- Sub-module mod_counter, parameterised by MODULUS, with enable, clear, wrap flag and value output. It serves as align_ctr and is reusable elsewhere in the codebase.

Test Plan:
- AXIS_BYTES=1, MIN=60, ALIGN=4, 10-byte packet, sink always ready:
  - Output is 60 beats.
  - Bytes 0-9 equal the input; beats 10-59 are 0x00.
  - tlast only on beat 59.
  - axis_i_tready low for the 50 pad cycles.
- Same config, 62-byte packet: 64 beats out, 2 pad beats, tlast on beat 63.
- Same config, 64-byte packet: passes unchanged with zero pad beats; the next packet starts back-to-back with no bubble.
- MIN=0, ALIGN=4, PAD_BYTE=8'hAA, AXIS_BYTES=2, 5-beat packet:
  - 8 beats out; pad beats are 16'hAAAA.
  - Random tready at 30% stalls; output data is held stable while stalled.
- Assert sresetn low during the PAD phase of a 3-beat packet:
  - tvalid drops asynchronously.
  - After release, a new 1-beat packet is padded to a full 60 beats, confirming the counters were cleared.
- With AXIS_PACKET_PADDER_STATS_EN defined, send packets of lengths 10, 64 and 62: pad_pkt_count=2 and pad_beat_count=52.

Source files
------------

// File: rtl/axis_padder_pkg.sv
// Shared types and width helpers for the AXIS packet padder and its counters.
package axis_padder_pkg;

  typedef enum logic {
    PASS = 1'b0,
    PAD  = 1'b1
  } state_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int beat_ctr_width(input int min_beats);
    return ctr_width(min_beats);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MODULUS counter with enable and synchronous clear; wrap_o flags the
// enabled step that returns the count to zero.
module mod_counter
  import axis_padder_pkg::*;
#(
  parameter int  MODULUS = 4,
  localparam int W       = ctr_width(MODULUS - 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  output logic         wrap_o,
  output logic [W-1:0] value_o
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] value_q, value_d;

  assign wrap_o  = en_i && (value_q == LAST);
  assign value_o = value_q;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (en_i) begin
      value_d = (value_q == LAST) ? '0 : value_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

endmodule

// File: rtl/axis_packet_padder.sv
// Pads AXIS packets with fill beats to at least MIN_BEATS and a multiple of
// ALIGN_BEATS. Optional fill statistics: define AXIS_PACKET_PADDER_STATS_EN.
module axis_packet_padder
  import axis_padder_pkg::*;
#(
  parameter int         AXIS_BYTES  = 1,
  parameter int         MIN_BEATS   = 60,
  parameter int         ALIGN_BEATS = 4,
  parameter logic [7:0] PAD_BYTE    = 8'h00
) (
  input  logic                    clk,
  input  logic                    sresetn,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata
`ifdef AXIS_PACKET_PADDER_STATS_EN
  ,
  output logic [31:0]             pad_pkt_count,
  output logic [31:0]             pad_beat_count
`endif
);

  localparam int                    BW         = beat_ctr_width(MIN_BEATS);
  localparam int                    AW         = ctr_width(ALIGN_BEATS - 1);
  localparam logic [BW-1:0]         MIN_CNT    = BW'(MIN_BEATS);
  localparam logic [AW-1:0]         ALIGN_LAST = AW'(ALIGN_BEATS - 1);
  localparam logic [AXIS_BYTES*8-1:0] PAD_WORD = {AXIS_BYTES{PAD_BYTE}};

  if (ALIGN_BEATS < 1) begin : g_bad_align
    $error("axis_packet_padder: ALIGN_BEATS must be >= 1");
  end
  if (AXIS_BYTES < 1) begin : g_bad_bytes
    $error("axis_packet_padder: AXIS_BYTES must be >= 1");
  end

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d, beat_inc;
  logic [AW-1:0] align_val;
  logic          align_wrap_unused;
  logic          in_pad, xfer, below_min, need_pad, adv, clr;

  assign in_pad   = (state_q == PAD);
  assign xfer     = (in_pad || axis_i_tvalid) && axis_o_tready;
  assign beat_inc = (beat_q == MIN_CNT) ? beat_q : beat_q + BW'(1);

  // need_pad looks at the counters as they will be after this beat transfers.
  if (MIN_BEATS > 1) begin : g_min
    assign below_min = (beat_inc < MIN_CNT);
  end else begin : g_no_min
    assign below_min = 1'b0;
  end
  assign need_pad = below_min || (align_val != ALIGN_LAST);

  mod_counter #(
    .MODULUS (ALIGN_BEATS)
  ) u_align_ctr (
    .clk     (clk),
    .rst_n   (sresetn),
    .en_i    (adv),
    .clr_i   (clr),
    .wrap_o  (align_wrap_unused),
    .value_o (align_val)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    adv           = 1'b0;
    clr           = 1'b0;
    axis_o_tdata  = axis_i_tdata;
    axis_o_tvalid = axis_i_tvalid;
    axis_o_tlast  = axis_i_tlast && !need_pad;
    axis_i_tready = axis_o_tready;

    unique case (state_q)
      PASS: begin
        if (xfer) begin
          if (axis_i_tlast && !need_pad) begin
            clr = 1'b1;
          end else begin
            adv = 1'b1;
            if (axis_i_tlast) state_d = PAD;
          end
        end
      end
      PAD: begin
        axis_i_tready = 1'b0;
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = PAD_WORD;
        axis_o_tlast  = !need_pad;
        if (xfer) begin
          if (!need_pad) begin
            clr     = 1'b1;
            state_d = PASS;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = PASS;
    endcase

    if (clr)      beat_d = '0;
    else if (adv) beat_d = beat_inc;
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q <= PASS;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

`ifdef AXIS_PACKET_PADDER_STATS_EN
  logic [31:0] pad_pkt_q, pad_beat_q;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      pad_pkt_q  <= '0;
      pad_beat_q <= '0;
    end else begin
      if (!in_pad && state_d == PAD) pad_pkt_q  <= pad_pkt_q + 32'd1;
      if (in_pad && xfer)            pad_beat_q <= pad_beat_q + 32'd1;
    end
  end

  assign pad_pkt_count  = pad_pkt_q;
  assign pad_beat_count = pad_beat_q;
`endif

endmodule

// File: tb/tb_axis_packet_padder.sv
// Randomised bench for axis_packet_padder against a packet-length reference model.
module tb_axis_packet_padder;

  logic clk = 1'b0;
  logic sresetn = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 1 byte, MIN 60, ALIGN 4, fill 0x00
  logic       a_i_tready, a_i_tvalid = 1'b0, a_i_tlast = 1'b0;
  logic [7:0] a_i_tdata = '0;
  logic       a_o_tready = 1'b0, a_o_tvalid, a_o_tlast;
  logic [7:0] a_o_tdata;
`ifdef AXIS_PACKET_PADDER_STATS_EN
  logic [31:0] a_pad_pkt_count, a_pad_beat_count;
`endif

  // Instance B: 2 bytes, MIN 0, ALIGN 4, fill 0xAA
  logic        b_i_tready, b_i_tvalid = 1'b0, b_i_tlast = 1'b0;
  logic [15:0] b_i_tdata = '0;
  logic        b_o_tready = 1'b0, b_o_tvalid, b_o_tlast;
  logic [15:0] b_o_tdata;
`ifdef AXIS_PACKET_PADDER_STATS_EN
  logic [31:0] b_pad_pkt_count, b_pad_beat_count;
`endif

  // Instance C: 1 byte, MIN 0, ALIGN 1 (padding fully disabled)
  logic       c_i_tready, c_i_tvalid = 1'b0, c_i_tlast = 1'b0;
  logic [7:0] c_i_tdata = '0;
  logic       c_o_tready = 1'b0, c_o_tvalid, c_o_tlast;
  logic [7:0] c_o_tdata;
`ifdef AXIS_PACKET_PADDER_STATS_EN
  logic [31:0] c_pad_pkt_count, c_pad_beat_count;
`endif

  axis_packet_padder #(.AXIS_BYTES(1), .MIN_BEATS(60), .ALIGN_BEATS(4), .PAD_BYTE(8'h00)) dut_a (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(a_i_tready), .axis_i_tvalid(a_i_tvalid), .axis_i_tlast(a_i_tlast), .axis_i_tdata(a_i_tdata),
    .axis_o_tready(a_o_tready), .axis_o_tvalid(a_o_tvalid), .axis_o_tlast(a_o_tlast), .axis_o_tdata(a_o_tdata)
`ifdef AXIS_PACKET_PADDER_STATS_EN
    , .pad_pkt_count(a_pad_pkt_count), .pad_beat_count(a_pad_beat_count)
`endif
  );

  axis_packet_padder #(.AXIS_BYTES(2), .MIN_BEATS(0), .ALIGN_BEATS(4), .PAD_BYTE(8'hAA)) dut_b (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(b_i_tready), .axis_i_tvalid(b_i_tvalid), .axis_i_tlast(b_i_tlast), .axis_i_tdata(b_i_tdata),
    .axis_o_tready(b_o_tready), .axis_o_tvalid(b_o_tvalid), .axis_o_tlast(b_o_tlast), .axis_o_tdata(b_o_tdata)
`ifdef AXIS_PACKET_PADDER_STATS_EN
    , .pad_pkt_count(b_pad_pkt_count), .pad_beat_count(b_pad_beat_count)
`endif
  );

  axis_packet_padder #(.AXIS_BYTES(1), .MIN_BEATS(0), .ALIGN_BEATS(1), .PAD_BYTE(8'h55)) dut_c (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(c_i_tready), .axis_i_tvalid(c_i_tvalid), .axis_i_tlast(c_i_tlast), .axis_i_tdata(c_i_tdata),
    .axis_o_tready(c_o_tready), .axis_o_tvalid(c_o_tvalid), .axis_o_tlast(c_o_tlast), .axis_o_tdata(c_o_tdata)
`ifdef AXIS_PACKET_PADDER_STATS_EN
    , .pad_pkt_count(c_pad_pkt_count), .pad_beat_count(c_pad_beat_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Output beats captured by the most recent run_stream call
  logic [15:0] out_data[$];
  logic        out_last[$];
  int          out_cyc[$];
  int          itready_low;

  // Streams packets of the given lengths through instance sel (0=A, 1=B),
  // then compares every output beat with the padded-length model.
  task automatic run_stream(input string name, input int sel, input int lens[$], input int ready_pct);
    logic [15:0] src_data[$];
    logic        src_last[$];
    logic [15:0] exp_d[$];
    logic        exp_l[$];
    logic [15:0] mask, padw, od, held_d;
    logic        ov, ol, ir, orr, iv, held_l, stalled;
    int          min_b, al, idx, cyc, pkts_done, base, n;

    mask  = (sel == 0) ? 16'h00FF : 16'hFFFF;
    padw  = (sel == 0) ? 16'h0000 : 16'hAAAA;
    min_b = (sel == 0) ? 60 : 0;
    al    = 4;
    out_data.delete(); out_last.delete(); out_cyc.delete();
    itready_low = 0;

    base = 0;
    foreach (lens[p]) begin
      int total;
      for (int j = 0; j < lens[p]; j++) begin
        src_data.push_back(16'($urandom) & mask);
        src_last.push_back(j == lens[p] - 1);
      end
      total = (lens[p] < min_b) ? min_b : lens[p];
      total = ((total + al - 1) / al) * al;
      for (int j = 0; j < total; j++) begin
        exp_d.push_back((j < lens[p]) ? src_data[base + j] : padw);
        exp_l.push_back(j == total - 1);
      end
      base += lens[p];
    end

    idx = 0; cyc = 0; pkts_done = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (pkts_done < lens.size() && cyc < 20000) begin
      @(posedge clk); #1;
      iv  = (idx < src_data.size());
      orr = ($urandom_range(99) < ready_pct);
      if (sel == 0) begin
        a_i_tvalid = iv; a_i_tdata = iv ? src_data[idx][7:0] : '0;
        a_i_tlast = iv ? src_last[idx] : 1'b0; a_o_tready = orr;
      end else begin
        b_i_tvalid = iv; b_i_tdata = iv ? src_data[idx] : '0;
        b_i_tlast = iv ? src_last[idx] : 1'b0; b_o_tready = orr;
      end
      @(negedge clk);
      if (sel == 0) begin
        ov = a_o_tvalid; ol = a_o_tlast; od = {8'h00, a_o_tdata}; ir = a_i_tready;
      end else begin
        ov = b_o_tvalid; ol = b_o_tlast; od = b_o_tdata; ir = b_i_tready;
      end
      if (stalled) begin
        checks++;
        if (!ov || od !== held_d || ol !== held_l) begin
          errors++;
          $display("FAIL %s stall_hold cyc %0d: got v=%0b d=%h l=%0b, expected v=1 d=%h l=%0b",
                   name, cyc, ov, od, ol, held_d, held_l);
        end
      end
      if (ov && orr) begin
        out_data.push_back(od); out_last.push_back(ol); out_cyc.push_back(cyc);
        if (ol) pkts_done++;
      end
      stalled = ov && !orr;
      held_d  = od;
      held_l  = ol;
      if (iv && ir) idx++;
      if (!ir) itready_low++;
      cyc++;
    end
    @(posedge clk); #1;
    if (sel == 0) begin a_i_tvalid = 1'b0; a_i_tlast = 1'b0; end
    else          begin b_i_tvalid = 1'b0; b_i_tlast = 1'b0; end

    if (cyc >= 20000) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d packets, expected %0d", name, pkts_done, lens.size());
    end
    checks++;
    if (out_data.size() != exp_d.size()) begin
      errors++;
      $display("FAIL %s beat_count: got %0d, expected %0d", name, out_data.size(), exp_d.size());
    end
    n = (out_data.size() < exp_d.size()) ? out_data.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_data[i] !== exp_d[i] || out_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL %s beat %0d: got d=%h l=%0b, expected d=%h l=%0b",
                 name, i, out_data[i], out_last[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (a_o_tvalid !== 1'b0 || b_o_tvalid !== 1'b0 || a_o_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got a_v=%0b b_v=%0b a_l=%0b, expected 0 0 0", a_o_tvalid, b_o_tvalid, a_o_tlast);
    end
    a_o_tready = 1'b1; b_o_tready = 1'b1;
    #1;
    checks++;
    if (a_i_tready !== 1'b1 || b_i_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got a=%0b b=%0b, expected 1 1", a_i_tready, b_i_tready);
    end
    repeat (3) @(posedge clk);
    #1 sresetn = 1'b1;
  endtask

  task automatic test_min_pad();
    int lens[$];
    lens.push_back(10);
    run_stream("min_pad_10", 0, lens, 100);
    checks++;
    if (itready_low != 50) begin
      errors++;
      $display("FAIL min_pad_10 tready_low: got %0d cycles, expected 50", itready_low);
    end
  endtask

  task automatic test_align_pad();
    int lens[$];
    lens.push_back(62);
    run_stream("align_pad_62", 0, lens, 100);
  endtask

  task automatic test_back_to_back();
    int lens[$];
    lens.push_back(64);
    lens.push_back(10);
    run_stream("b2b_64_10", 0, lens, 100);
    checks++;
    if (out_cyc.size() < 65 || out_cyc[64] - out_cyc[63] != 1) begin
      errors++;
      $display("FAIL b2b_bubble: got gap %0d, expected 1",
               (out_cyc.size() < 65) ? -1 : out_cyc[64] - out_cyc[63]);
    end
  endtask

  task automatic test_wide_stall();
    int lens[$];
    lens.push_back(5);
    run_stream("wide_5_stall", 1, lens, 70);
    lens.delete();
    for (int i = 0; i < 6; i++) lens.push_back($urandom_range(12, 1));
    run_stream("wide_random", 1, lens, 50);
  endtask

  task automatic test_random_narrow();
    int lens[$];
    for (int i = 0; i < 4; i++) lens.push_back($urandom_range(100, 1));
    run_stream("narrow_random", 0, lens, 70);
  endtask

  task automatic test_no_pad();
    logic [7:0] d;
    logic       l;
    c_o_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      d = 8'($urandom);
      l = (i == 0) ? 1'b1 : 1'($urandom_range(1));
      c_i_tvalid = 1'b1; c_i_tdata = d; c_i_tlast = l;
      @(negedge clk);
      checks++;
      if (c_o_tvalid !== 1'b1 || c_o_tdata !== d || c_o_tlast !== l || c_i_tready !== 1'b1) begin
        errors++;
        $display("FAIL no_pad beat %0d: got v=%0b d=%h l=%0b r=%0b, expected v=1 d=%h l=%0b r=1",
                 i, c_o_tvalid, c_o_tdata, c_o_tlast, c_i_tready, d, l);
      end
    end
    @(posedge clk); #1;
    c_i_tvalid = 1'b0; c_i_tlast = 1'b0;
  endtask

  task automatic test_reset_mid_pad();
    int lens[$];
    a_o_tready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      a_i_tvalid = 1'b1; a_i_tdata = 8'($urandom); a_i_tlast = (j == 2);
    end
    @(posedge clk); #1;
    a_i_tvalid = 1'b0; a_i_tlast = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_o_tvalid !== 1'b1 || a_i_tready !== 1'b0) begin
      errors++;
      $display("FAIL mid_pad_state: got v=%0b r=%0b, expected v=1 r=0", a_o_tvalid, a_i_tready);
    end
    #1 sresetn = 1'b0;
    #1;
    checks++;
    if (a_o_tvalid !== 1'b0 || a_i_tready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%0b r=%0b, expected v=0 r=1", a_o_tvalid, a_i_tready);
    end
    @(posedge clk); #1 sresetn = 1'b1;
    lens.push_back(1);
    run_stream("after_reset_1", 0, lens, 100);
  endtask

`ifdef AXIS_PACKET_PADDER_STATS_EN
  task automatic test_stats();
    int lens[$];
    logic [31:0] p0, b0;
    p0 = a_pad_pkt_count;
    b0 = a_pad_beat_count;
    lens.push_back(10); lens.push_back(64); lens.push_back(62);
    run_stream("stats_run", 0, lens, 100);
    @(negedge clk);
    checks++;
    if (a_pad_pkt_count - p0 != 32'd2 || a_pad_beat_count - b0 != 32'd52) begin
      errors++;
      $display("FAIL stats: got pkts=%0d beats=%0d, expected 2 52",
               a_pad_pkt_count - p0, a_pad_beat_count - b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_min_pad();
    test_align_pad();
    test_back_to_back();
    test_wide_stall();
    test_random_narrow();
    test_no_pad();
    test_reset_mid_pad();
`ifdef AXIS_PACKET_PADDER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
